// File: rtl/pong_pkg.sv
// Shared Pong definitions: game state and winner encodings plus the default
// playfield geometry used by the match engine, paddle and renderer blocks.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    localparam int DEF_POS_W       = 10;
    localparam int DEF_FIELD_W     = 640;
    localparam int DEF_FIELD_H     = 480;
    localparam int DEF_BALL_SIZE   = 8;
    localparam int DEF_PADDLE_W    = 10;
    localparam int DEF_PADDLE_H    = 100;
    localparam int DEF_P1_X        = 20;
    localparam int DEF_P2_X        = 610;
    localparam int DEF_SPEED_X     = 2;
    localparam int DEF_SPEED_Y     = 1;
    localparam int DEF_SCORE_W     = 4;
    localparam int DEF_WIN_SCORE   = 9;
    localparam int DEF_SERVE_TICKS = 60;

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational paddle collision: the ball's leading edge crosses the paddle
// face this tick while the ball overlaps the paddle vertically.
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter int POS_W          = DEF_POS_W,
    parameter int FACE_X         = DEF_P1_X + DEF_PADDLE_W,
    parameter bit APPROACH_RIGHT = 1'b0,
    parameter int BALL_SIZE      = DEF_BALL_SIZE,
    parameter int PADDLE_H       = DEF_PADDLE_H,
    parameter int SPEED_X        = DEF_SPEED_X
) (
    input  logic [POS_W-1:0] ball_x,
    input  logic [POS_W-1:0] ball_y,
    input  logic [POS_W-1:0] paddle_y,
    input  logic             moving_right,
    output logic             hit
);

    localparam int EW = POS_W + 1;
    localparam logic [EW-1:0] FACE_E   = EW'(FACE_X);
    localparam logic [EW-1:0] BALL_E   = EW'(BALL_SIZE);
    localparam logic [EW-1:0] PADDLE_E = EW'(PADDLE_H);
    localparam logic [EW-1:0] SPEED_E  = EW'(SPEED_X);

    logic [EW-1:0] x_e_s;
    logic [EW-1:0] y_e_s;
    logic [EW-1:0] py_e_s;
    logic          overlap_s;
    logic          crossing_s;

    assign x_e_s  = {1'b0, ball_x};
    assign y_e_s  = {1'b0, ball_y};
    assign py_e_s = {1'b0, paddle_y};

    assign overlap_s = (y_e_s + BALL_E > py_e_s) && (y_e_s < py_e_s + PADDLE_E);

    // Right-moving balls lead with their right edge; left-moving with their left edge
    generate
        if (APPROACH_RIGHT) begin : g_right
            assign crossing_s = moving_right
                             && (x_e_s + BALL_E <= FACE_E)
                             && (x_e_s + BALL_E + SPEED_E >= FACE_E);
        end else begin : g_left
            assign crossing_s = !moving_right
                             && (x_e_s >= FACE_E)
                             && (x_e_s <= FACE_E + SPEED_E);
        end
    endgenerate

    assign hit = crossing_s && overlap_s;

endmodule

// File: rtl/pong_match_engine.sv
// Pong gameplay core: ball kinematics, wall/paddle collision, scoring, serve
// delay, pause and game-over sequencing, stepped once per tick.
module pong_match_engine
    import pong_pkg::*;
#(
    parameter int POS_W       = DEF_POS_W,
    parameter int FIELD_W     = DEF_FIELD_W,
    parameter int FIELD_H     = DEF_FIELD_H,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PADDLE_W    = DEF_PADDLE_W,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int P1_X        = DEF_P1_X,
    parameter int P2_X        = DEF_P2_X,
    parameter int SPEED_X     = DEF_SPEED_X,
    parameter int SPEED_Y     = DEF_SPEED_Y,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SERVE_TICKS = DEF_SERVE_TICKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic [POS_W-1:0]   p1_y,
    input  logic [POS_W-1:0]   p2_y,
    output logic [POS_W-1:0]   ball_x,
    output logic [POS_W-1:0]   ball_y,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [2:0]         state,
    output logic [1:0]         winner,
    output logic               bounce,
    output logic               point_p1,
    output logic               point_p2
);

    localparam int EW    = POS_W + 1;
    localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

    localparam logic [POS_W-1:0]   CENTRE_X   = POS_W'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0]   CENTRE_Y   = POS_W'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0]   LEFT_STOP  = POS_W'(P1_X + PADDLE_W);
    localparam logic [POS_W-1:0]   RIGHT_STOP = POS_W'(P2_X - BALL_SIZE);
    localparam logic [EW-1:0]      X_MAX_E    = EW'(FIELD_W - BALL_SIZE);
    localparam logic [EW-1:0]      Y_MAX_E    = EW'(FIELD_H - BALL_SIZE);
    localparam logic [EW-1:0]      SPX_E      = EW'(SPEED_X);
    localparam logic [EW-1:0]      SPY_E      = EW'(SPEED_Y);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

    game_state_e        state_r, state_nxt_s;
    winner_e            winner_r, winner_nxt_s;
    logic [POS_W-1:0]   ball_x_r, ball_x_nxt_s;
    logic [POS_W-1:0]   ball_y_r, ball_y_nxt_s;
    logic               dx_r, dx_nxt_s;   // 1 = moving right
    logic               dy_r, dy_nxt_s;   // 1 = moving down
    logic [SCORE_W-1:0] score_p1_r, score_p1_nxt_s;
    logic [SCORE_W-1:0] score_p2_r, score_p2_nxt_s;
    logic [CNT_W-1:0]   serve_cnt_r, serve_cnt_nxt_s;
    logic               bounce_r, bounce_nxt_s;
    logic               point_p1_r, point_p1_nxt_s;
    logic               point_p2_r, point_p2_nxt_s;

    logic               hit_l_s, hit_r_s, miss_l_s, miss_r_s;
    logic [POS_W-1:0]   y_step_s, x_step_s;
    logic               dy_step_s;
    logic [SCORE_W-1:0] score_p1_inc_s, score_p2_inc_s;

    pong_paddle_hit #(
        .POS_W(POS_W), .FACE_X(P1_X + PADDLE_W), .APPROACH_RIGHT(1'b0),
        .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H), .SPEED_X(SPEED_X)
    ) u_hit_p1 (
        .ball_x(ball_x_r), .ball_y(ball_y_r), .paddle_y(p1_y),
        .moving_right(dx_r), .hit(hit_l_s)
    );

    pong_paddle_hit #(
        .POS_W(POS_W), .FACE_X(P2_X), .APPROACH_RIGHT(1'b1),
        .BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H), .SPEED_X(SPEED_X)
    ) u_hit_p2 (
        .ball_x(ball_x_r), .ball_y(ball_y_r), .paddle_y(p2_y),
        .moving_right(dx_r), .hit(hit_r_s)
    );

    assign miss_l_s = !dx_r && ({1'b0, ball_x_r} <= SPX_E);
    assign miss_r_s = dx_r && ({1'b0, ball_x_r} + SPX_E >= X_MAX_E);
    assign x_step_s = dx_r ? POS_W'({1'b0, ball_x_r} + SPX_E)
                           : POS_W'({1'b0, ball_x_r} - SPX_E);
    assign score_p1_inc_s = score_p1_r + {{(SCORE_W-1){1'b0}}, 1'b1};
    assign score_p2_inc_s = score_p2_r + {{(SCORE_W-1){1'b0}}, 1'b1};

    // Vertical step with wall clamp and reflection, evaluated every cycle
    always_comb begin
        y_step_s  = ball_y_r;
        dy_step_s = dy_r;
        if (dy_r) begin
            if ({1'b0, ball_y_r} + SPY_E >= Y_MAX_E) begin
                y_step_s  = POS_W'(Y_MAX_E);
                dy_step_s = 1'b0;
            end else begin
                y_step_s  = POS_W'({1'b0, ball_y_r} + SPY_E);
            end
        end else begin
            if ({1'b0, ball_y_r} <= SPY_E) begin
                y_step_s  = '0;
                dy_step_s = 1'b1;
            end else begin
                y_step_s  = POS_W'({1'b0, ball_y_r} - SPY_E);
            end
        end
    end

    // Next-state and datapath update; everything holds unless tick is high
    always_comb begin
        state_nxt_s     = state_r;
        winner_nxt_s    = winner_r;
        ball_x_nxt_s    = ball_x_r;
        ball_y_nxt_s    = ball_y_r;
        dx_nxt_s        = dx_r;
        dy_nxt_s        = dy_r;
        score_p1_nxt_s  = score_p1_r;
        score_p2_nxt_s  = score_p2_r;
        serve_cnt_nxt_s = serve_cnt_r;
        bounce_nxt_s    = 1'b0;
        point_p1_nxt_s  = 1'b0;
        point_p2_nxt_s  = 1'b0;
        if (tick) begin
            case (state_r)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        state_nxt_s     = ST_SERVE;
                        score_p1_nxt_s  = '0;
                        score_p2_nxt_s  = '0;
                        winner_nxt_s    = WIN_NONE;
                        serve_cnt_nxt_s = SERVE_LOAD;
                        ball_x_nxt_s    = CENTRE_X;
                        ball_y_nxt_s    = CENTRE_Y;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_SERVE: begin
                    if (serve_cnt_r == '0) begin
                        state_nxt_s = ST_PLAY;
                    end else begin
                        serve_cnt_nxt_s = serve_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_nxt_s = ST_PAUSE;
                    end else if (hit_l_s) begin
                        ball_x_nxt_s = LEFT_STOP;
                        dx_nxt_s     = 1'b1;
                        bounce_nxt_s = 1'b1;
                        ball_y_nxt_s = y_step_s;
                        dy_nxt_s     = dy_step_s;
                    end else if (hit_r_s) begin
                        ball_x_nxt_s = RIGHT_STOP;
                        dx_nxt_s     = 1'b0;
                        bounce_nxt_s = 1'b1;
                        ball_y_nxt_s = y_step_s;
                        dy_nxt_s     = dy_step_s;
                    end else if (miss_l_s) begin
                        score_p2_nxt_s = score_p2_inc_s;
                        point_p2_nxt_s = 1'b1;
                        if (score_p2_inc_s == WIN_S) begin
                            state_nxt_s  = ST_GAME_OVER;
                            winner_nxt_s = WIN_P2;
                        end else begin
                            state_nxt_s     = ST_SERVE;
                            serve_cnt_nxt_s = SERVE_LOAD;
                            ball_x_nxt_s    = CENTRE_X;
                            ball_y_nxt_s    = CENTRE_Y;
                            dx_nxt_s        = 1'b0;   // serve toward p1, who conceded
                        end
                    end else if (miss_r_s) begin
                        score_p1_nxt_s = score_p1_inc_s;
                        point_p1_nxt_s = 1'b1;
                        if (score_p1_inc_s == WIN_S) begin
                            state_nxt_s  = ST_GAME_OVER;
                            winner_nxt_s = WIN_P1;
                        end else begin
                            state_nxt_s     = ST_SERVE;
                            serve_cnt_nxt_s = SERVE_LOAD;
                            ball_x_nxt_s    = CENTRE_X;
                            ball_y_nxt_s    = CENTRE_Y;
                            dx_nxt_s        = 1'b1;
                        end
                    end else begin
                        ball_x_nxt_s = x_step_s;
                        ball_y_nxt_s = y_step_s;
                        dy_nxt_s     = dy_step_s;
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_nxt_s = ST_PLAY;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            winner_r    <= WIN_NONE;
            ball_x_r    <= CENTRE_X;
            ball_y_r    <= CENTRE_Y;
            dx_r        <= 1'b1;
            dy_r        <= 1'b1;
            score_p1_r  <= '0;
            score_p2_r  <= '0;
            serve_cnt_r <= '0;
            bounce_r    <= 1'b0;
            point_p1_r  <= 1'b0;
            point_p2_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            winner_r    <= winner_nxt_s;
            ball_x_r    <= ball_x_nxt_s;
            ball_y_r    <= ball_y_nxt_s;
            dx_r        <= dx_nxt_s;
            dy_r        <= dy_nxt_s;
            score_p1_r  <= score_p1_nxt_s;
            score_p2_r  <= score_p2_nxt_s;
            serve_cnt_r <= serve_cnt_nxt_s;
            bounce_r    <= bounce_nxt_s;
            point_p1_r  <= point_p1_nxt_s;
            point_p2_r  <= point_p2_nxt_s;
        end
    end

    assign ball_x   = ball_x_r;
    assign ball_y   = ball_y_r;
    assign score_p1 = score_p1_r;
    assign score_p2 = score_p2_r;
    assign state    = state_r;
    assign winner   = winner_r;
    assign bounce   = bounce_r;
    assign point_p1 = point_p1_r;
    assign point_p2 = point_p2_r;

endmodule
